// File: rtl/vec_fetch_pkg.sv
// vec_fetch_pkg
// Shared definitions for the vector fetch unit: the FSM state type and the
// default parameter set used by vec_fetch_unit and vec_fetch_addr_gen.
// No ports.

package vec_fetch_pkg;

   // IDLE  : waiting for start
   // ISSUE : one memory read issued per cycle
   // DRAIN : all reads issued, waiting for the last return
   // HOLD  : data_out complete, waiting for ready
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } fetch_state_t;

   localparam int unsigned DEF_NO_OF_ELEM = 16;
   localparam int unsigned DEF_MEM_DEPTH  = 12;
   localparam int unsigned DEF_WORD_SIZE  = 32;
   localparam int unsigned DEF_RD_LATENCY = 1;

endpackage

// File: rtl/vec_fetch_addr_gen.sv
// vec_fetch_addr_gen
// Address generator for the vector fetch unit. On load it captures the base
// address, the stride and the number of elements to fetch; every step cycle
// it advances the address accumulator by the stride and bumps the issue index.
// Addresses wrap modulo 2^MEM_DEPTH.
//
// Configuration macro: VEC_FETCH_STRIDE_EN
//   defined   : the stride input is latched and honoured
//   undefined : the stride input is ignored and the increment is 1
//
// Ports
//   clk        in   clock
//   RESET      in   synchronous active-high reset
//   flush      in   abandon the current sequence (clears all state)
//   load       in   accept a new sequence (base_addr, stride, count)
//   step       in   one address is issued this cycle
//   base_addr  in   address of element 0
//   stride     in   address increment between elements
//   count      in   elements in the sequence, 1..NO_OF_ELEM
//   addr       out  current issue address
//   idx        out  current issue index
//   last       out  current issue is the final one of the sequence

module vec_fetch_addr_gen
   import vec_fetch_pkg::*;
#(
   parameter int unsigned NO_OF_ELEM = DEF_NO_OF_ELEM,
   parameter int unsigned MEM_DEPTH  = DEF_MEM_DEPTH
) (
   input  logic                          clk,
   input  logic                          RESET,
   input  logic                          flush,
   input  logic                          load,
   input  logic                          step,
   input  logic [MEM_DEPTH-1:0]          base_addr,
   input  logic [MEM_DEPTH-1:0]          stride,
   input  logic [$clog2(NO_OF_ELEM):0]   count,
   output logic [MEM_DEPTH-1:0]          addr,
   output logic [$clog2(NO_OF_ELEM)-1:0] idx,
   output logic                          last
);

   localparam int unsigned IDX_W = $clog2(NO_OF_ELEM);

   logic [MEM_DEPTH-1:0] acc_q;
   logic [MEM_DEPTH-1:0] inc_q;
   logic [IDX_W-1:0]     cnt_q;
   logic [IDX_W-1:0]     last_idx_q;

`ifdef VEC_FETCH_STRIDE_EN
   always_ff @(posedge clk) begin
      if (RESET || flush) begin
         inc_q <= '0;
      end else if (load) begin
         inc_q <= stride;
      end
   end
`else
   // Unit-stride build: the port stays for interface compatibility only.
   assign inc_q = MEM_DEPTH'(1);

   logic unused_stride;
   assign unused_stride = ^stride;
`endif

   always_ff @(posedge clk) begin
      if (RESET || flush) begin
         acc_q      <= '0;
         cnt_q      <= '0;
         last_idx_q <= '0;
      end else if (load) begin
         acc_q      <= base_addr;
         cnt_q      <= '0;
         // count is never 0 here, so count-1 fits in IDX_W bits
         last_idx_q <= IDX_W'(count - 1'b1);
      end else if (step) begin
         acc_q <= acc_q + inc_q;
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign addr = acc_q;
   assign idx  = cnt_q;
   assign last = (cnt_q == last_idx_q);

endmodule

// File: rtl/vec_fetch_unit.sv
// vec_fetch_unit
// Fetches up to NO_OF_ELEM words from a memory with fixed read latency
// RD_LATENCY and presents them as one vector with a valid/ready handshake.
// One address is issued per cycle; returned words are steered into their
// element slot by an RD_LATENCY-deep shift register of {valid, index}.
// writer_busy aborts any fetch and discards in-flight returns.
//
// Configuration macro: VEC_FETCH_STRIDE_EN (see vec_fetch_addr_gen); without
// it every fetch is unit-stride.
//
// Ports
//   clk          in   clock
//   RESET        in   synchronous active-high reset
//   start        in   fetch request, accepted only in IDLE
//   base_addr    in   address of element 0
//   stride       in   address increment between elements
//   vlen         in   element count; 0 or >NO_OF_ELEM means NO_OF_ELEM
//   ins          in   instruction mode: fetch a single word
//   writer_busy  in   abort / flush request
//   mem_data     in   memory read data, RD_LATENCY cycles after mem_en
//   mem_addr     out  memory read address
//   mem_en       out  memory read enable
//   data_out     out  fetched vector, element i at [i*WORD_SIZE +: WORD_SIZE]
//   elem_mask    out  bit i set when element i has been loaded
//   valid        out  data_out complete
//   ready        in   consumer accepts data_out
//   busy         out  fetch unit not in IDLE

module vec_fetch_unit
   import vec_fetch_pkg::*;
#(
   parameter int unsigned NO_OF_ELEM = DEF_NO_OF_ELEM,
   parameter int unsigned MEM_DEPTH  = DEF_MEM_DEPTH,
   parameter int unsigned WORD_SIZE  = DEF_WORD_SIZE,
   parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
   input  logic                             clk,
   input  logic                             RESET,
   input  logic                             start,
   input  logic [MEM_DEPTH-1:0]             base_addr,
   input  logic [MEM_DEPTH-1:0]             stride,
   input  logic [$clog2(NO_OF_ELEM):0]      vlen,
   input  logic                             ins,
   input  logic                             writer_busy,
   input  logic [WORD_SIZE-1:0]             mem_data,
   output logic [MEM_DEPTH-1:0]             mem_addr,
   output logic                             mem_en,
   output logic [NO_OF_ELEM*WORD_SIZE-1:0]  data_out,
   output logic [NO_OF_ELEM-1:0]            elem_mask,
   output logic                             valid,
   input  logic                             ready,
   output logic                             busy
);

   localparam int unsigned IDX_W = $clog2(NO_OF_ELEM);
   localparam int unsigned CNT_W = IDX_W + 1;

   fetch_state_t                    state_q;
   logic                            valid_q;
   logic [NO_OF_ELEM*WORD_SIZE-1:0] data_q;
   logic [NO_OF_ELEM-1:0]           mask_q;

   // Return tracking: entry 0 is the newest issue, entry RD_LATENCY-1 lines
   // up with the word currently on mem_data.
   logic [RD_LATENCY-1:0]           pipe_v_q;
   logic [IDX_W-1:0]                pipe_idx_q [RD_LATENCY];

   logic                            accept;
   logic                            issue;
   logic                            capture;
   logic                            younger_pending;
   logic [CNT_W-1:0]                fetch_cnt;
   logic [IDX_W-1:0]                ag_idx;
   logic                            ag_last;
   logic [IDX_W-1:0]                head_idx;

   assign accept = (state_q == IDLE) && start;
   assign issue  = (state_q == ISSUE);

   // Number of reads for this request.
   always_comb begin
      if (ins) begin
         fetch_cnt = CNT_W'(1);
      end else if ((vlen == '0) || (vlen > CNT_W'(NO_OF_ELEM))) begin
         fetch_cnt = CNT_W'(NO_OF_ELEM);
      end else begin
         fetch_cnt = vlen;
      end
   end

   vec_fetch_addr_gen #(
      .NO_OF_ELEM (NO_OF_ELEM),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_addr_gen (
      .clk       (clk),
      .RESET     (RESET),
      .flush     (writer_busy),
      .load      (accept),
      .step      (issue),
      .base_addr (base_addr),
      .stride    (stride),
      .count     (fetch_cnt),
      .addr      (mem_addr),
      .idx       (ag_idx),
      .last      (ag_last)
   );

   always_ff @(posedge clk) begin
      if (RESET || writer_busy) begin
         pipe_v_q <= '0;
         for (int i = 0; i < int'(RD_LATENCY); i++) begin
            pipe_idx_q[i] <= '0;
         end
      end else begin
         pipe_v_q[0]   <= issue;
         pipe_idx_q[0] <= ag_idx;
         for (int i = 1; i < int'(RD_LATENCY); i++) begin
            pipe_v_q[i]   <= pipe_v_q[i-1];
            pipe_idx_q[i] <= pipe_idx_q[i-1];
         end
      end
   end

   assign head_idx = pipe_idx_q[RD_LATENCY-1];
   assign capture  = pipe_v_q[RD_LATENCY-1] && ((state_q == ISSUE) || (state_q == DRAIN));

   // In DRAIN no new reads enter the pipe, so the head is the final word
   // once nothing younger is still travelling behind it.
   always_comb begin
      younger_pending = 1'b0;
      for (int i = 0; i < int'(RD_LATENCY) - 1; i++) begin
         younger_pending = younger_pending | pipe_v_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         data_q  <= '0;
         mask_q  <= '0;
      end else if (writer_busy) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         mask_q  <= '0;
      end else begin
         if (capture) begin
            data_q[head_idx*WORD_SIZE +: WORD_SIZE] <= mem_data;
            mask_q[head_idx]                        <= 1'b1;
         end
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= ISSUE;
                  data_q  <= '0;
                  mask_q  <= '0;
               end
            end
            ISSUE: begin
               if (ag_last) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (capture && !younger_pending) begin
                  state_q <= HOLD;
                  valid_q <= 1'b1;
               end
            end
            HOLD: begin
               if (ready) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_en    = issue;
   assign busy      = (state_q != IDLE);
   assign valid     = valid_q;
   assign data_out  = data_q;
   assign elem_mask = mask_q;

endmodule

// File: tb/tb_vec_fetch_unit.sv
// tb_vec_fetch_unit
// Two instances (RD_LATENCY 1 and 3) share one stimulus stream. The driver
// pushes expected addresses and expected vectors into per-instance queues;
// the monitor pops and compares whenever the DUT issues a read or shows valid.

module tb_vec_fetch_unit;

   localparam int NE      = 16;
   localparam int MD      = 12;
   localparam int WS      = 32;
   localparam int LAT0    = 1;
   localparam int LAT1    = 3;
   localparam int TIMEOUT = 200;

   typedef struct {
      logic [NE*WS-1:0] data;
      logic [NE-1:0]    mask;
      int               start_cyc;
      int               n;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          RESET, start, ins, writer_busy, ready;
   logic [MD-1:0] base_addr, stride;
   logic [4:0]    vlen;

   logic [WS-1:0]    mem_data  [2];
   logic [MD-1:0]    mem_addr  [2];
   logic             mem_en    [2];
   logic [NE*WS-1:0] data_out  [2];
   logic [NE-1:0]    elem_mask [2];
   logic             valid     [2];
   logic             busy      [2];

   vec_fetch_unit #(
      .NO_OF_ELEM (NE), .MEM_DEPTH (MD), .WORD_SIZE (WS), .RD_LATENCY (LAT0)
   ) u_dut_l1 (
      .clk (clk), .RESET (RESET), .start (start), .base_addr (base_addr),
      .stride (stride), .vlen (vlen), .ins (ins), .writer_busy (writer_busy),
      .mem_data (mem_data[0]), .mem_addr (mem_addr[0]), .mem_en (mem_en[0]),
      .data_out (data_out[0]), .elem_mask (elem_mask[0]), .valid (valid[0]),
      .ready (ready), .busy (busy[0])
   );

   vec_fetch_unit #(
      .NO_OF_ELEM (NE), .MEM_DEPTH (MD), .WORD_SIZE (WS), .RD_LATENCY (LAT1)
   ) u_dut_l3 (
      .clk (clk), .RESET (RESET), .start (start), .base_addr (base_addr),
      .stride (stride), .vlen (vlen), .ins (ins), .writer_busy (writer_busy),
      .mem_data (mem_data[1]), .mem_addr (mem_addr[1]), .mem_en (mem_en[1]),
      .data_out (data_out[1]), .elem_mask (elem_mask[1]), .valid (valid[1]),
      .ready (ready), .busy (busy[1])
   );

   // Memory model: fixed-latency read pipes; idle slots carry a marker word.
   localparam logic [WS-1:0] IDLE_BUS = 32'hDEAD_BEEF;
   logic [WS-1:0] mem [1 << MD];
   logic [WS-1:0] rd_l1;
   logic [WS-1:0] rd_l3 [3];

   always @(posedge clk) begin
      rd_l1    <= mem_en[0] ? mem[mem_addr[0]] : IDLE_BUS;
      rd_l3[0] <= mem_en[1] ? mem[mem_addr[1]] : IDLE_BUS;
      rd_l3[1] <= rd_l3[0];
      rd_l3[2] <= rd_l3[1];
   end
   assign mem_data[0] = rd_l1;
   assign mem_data[1] = rd_l3[2];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   exp_t          exp_q0 [$];
   exp_t          exp_q1 [$];
   logic [MD-1:0] addr_q0 [$];
   logic [MD-1:0] addr_q1 [$];
   bit            seen     [2];
   bit            idle_due [2];

   task automatic check(input string name, input logic [NE*WS-1:0] act,
                        input logic [NE*WS-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [MD-1:0] eff_stride(input logic [MD-1:0] s);
`ifdef VEC_FETCH_STRIDE_EN
      return s;
`else
      return (s & '0) | MD'(1);
`endif
   endfunction

   // Reference: element i comes from base + i*stride (mod 2^MD); the rest are 0.
   function automatic exp_t model(input logic [MD-1:0] b, input logic [MD-1:0] s,
                                  input logic [4:0] vl, input logic in, input int sc);
      exp_t          e;
      logic [MD-1:0] a;
      e.n         = in ? 1 : (((vl == 0) || (int'(vl) > NE)) ? NE : int'(vl));
      e.data      = '0;
      e.mask      = '0;
      e.start_cyc = sc;
      for (int i = 0; i < e.n; i++) begin
         a                  = MD'(int'(b) + i * int'(eff_stride(s)));
         e.data[i*WS +: WS] = mem[a];
         e.mask[i]          = 1'b1;
      end
      return e;
   endfunction

   task automatic flush_sb();
      exp_q0.delete();
      exp_q1.delete();
      addr_q0.delete();
      addr_q1.delete();
      seen     = '{0, 0};
      idle_due = '{0, 0};
   endtask

   // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next.
   task automatic issue_fetch(input logic [MD-1:0] b, input logic [MD-1:0] s,
                              input logic [4:0] vl, input logic in);
      exp_t          e;
      logic [MD-1:0] a;
      base_addr = b;
      stride    = s;
      vlen      = vl;
      ins       = in;
      start     = 1'b1;
      e = model(b, s, vl, in, cyc);
      for (int i = 0; i < e.n; i++) begin
         a = MD'(int'(b) + i * int'(eff_stride(s)));
         addr_q0.push_back(a);
         addr_q1.push_back(a);
      end
      exp_q0.push_back(e);
      exp_q1.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < TIMEOUT; t++) begin
         @(posedge clk);
         #1;
         if (valid[0] && valid[1]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("valid_timeout", {valid[0], valid[1]}, 2'b11);
   endtask

   task automatic apply_reset();
      RESET = 1'b1;
      @(posedge clk);
      #1;
      RESET = 1'b0;
      flush_sb();
   endtask

   task automatic check_quiet(input string tag);
      for (int k = 0; k < 2; k++) begin
         check({tag, "_mem_en"}, mem_en[k], 0);
         check({tag, "_mem_addr"}, mem_addr[k], 0);
         check({tag, "_data_out"}, data_out[k], 0);
         check({tag, "_elem_mask"}, elem_mask[k], 0);
         check({tag, "_valid"}, valid[k], 0);
         check({tag, "_busy"}, busy[k], 0);
      end
   endtask

   // Full fetch: issue, wait for both instances, hold ready low, accept.
   task automatic run_fetch(input logic [MD-1:0] b, input logic [MD-1:0] s,
                            input logic [4:0] vl, input logic in, input int hold);
      bit ok;
      issue_fetch(b, s, vl, in);
      wait_valid(ok);
      if (ok) begin
         repeat (hold) begin
            @(posedge clk);
            #1;
         end
         ready = 1'b1;
         @(posedge clk);
         #1;
         ready = 1'b0;
         @(posedge clk);
         #1;
         check("scoreboard_drained",
               exp_q0.size() + exp_q1.size() + addr_q0.size() + addr_q1.size(), 0);
      end else begin
         apply_reset();
      end
   endtask

   task automatic mon_inst(input int k);
      int            lat;
      exp_t          e;
      logic [MD-1:0] ea;
      lat = (k == 0) ? LAT0 : LAT1;
      if (mem_en[k] === 1'b1) begin
         if (((k == 0) ? addr_q0.size() : addr_q1.size()) == 0) begin
            check("spurious_mem_en", mem_en[k], 0);
         end else begin
            if (k == 0) ea = addr_q0.pop_front();
            else        ea = addr_q1.pop_front();
            check("mem_addr", mem_addr[k], ea);
         end
      end
      if (idle_due[k]) begin
         check("valid_after_accept", valid[k], 0);
         check("busy_after_accept", busy[k], 0);
         idle_due[k] = 1'b0;
      end
      if (valid[k] === 1'b1) begin
         if (((k == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
            check("spurious_valid", valid[k], 0);
         end else begin
            e = (k == 0) ? exp_q0[0] : exp_q1[0];
            if (!seen[k]) begin
               check("start_to_valid_latency", cyc - e.start_cyc, 1 + e.n + lat);
               seen[k] = 1'b1;
            end
            check("data_out", data_out[k], e.data);
            check("elem_mask", elem_mask[k], e.mask);
            check("busy_in_hold", busy[k], 1);
            if (ready) begin
               if (k == 0) void'(exp_q0.pop_front());
               else        void'(exp_q1.pop_front());
               seen[k]     = 1'b0;
               idle_due[k] = 1'b1;
            end
         end
      end
   endtask

   initial begin
      RESET       = 1'b1;
      start       = 1'b0;
      ins         = 1'b0;
      writer_busy = 1'b0;
      ready       = 1'b0;
      base_addr   = '0;
      stride      = '0;
      vlen        = '0;
      for (int a = 0; a < (1 << MD); a++) mem[a] = WS'(a);
      fork
         begin : driver
            bit ok;
            repeat (3) @(posedge clk);
            #1;
            apply_reset();
            check_quiet("reset");

            // Unit stride, full vector, mem[a] = a.
            run_fetch(12'h100, 12'd1, 5'd16, 1'b0, 0);
            // Wrapping stride, short vector.
            run_fetch(12'hFFE, 12'd3, 5'd4, 1'b0, 1);
            // Instruction mode: one word regardless of vlen.
            run_fetch(12'h020, 12'd1, 5'd9, 1'b1, 0);
            // Clamp cases.
            run_fetch(12'h7F0, 12'd2, 5'd0, 1'b0, 0);
            run_fetch(12'h3A0, 12'd5, 5'd23, 1'b0, 2);

            for (int a = 0; a < (1 << MD); a++) mem[a] = $urandom;
            for (int r = 0; r < 24; r++) begin
               run_fetch(MD'($urandom), MD'($urandom_range(0, 300)),
                         5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0),
                         $urandom_range(0, 3));
            end

            // Abort during the 5th issue cycle, then a clean fetch.
            issue_fetch(12'h200, 12'd1, 5'd16, 1'b0);
            repeat (4) begin
               @(posedge clk);
               #1;
            end
            writer_busy = 1'b1;
            @(posedge clk);
            #1;
            writer_busy = 1'b0;
            flush_sb();
            for (int t = 0; t < 5; t++) begin
               for (int k = 0; k < 2; k++) begin
                  check("abort_busy", busy[k], 0);
                  check("abort_valid", valid[k], 0);
                  check("abort_mem_en", mem_en[k], 0);
                  check("abort_elem_mask", elem_mask[k], 0);
               end
               @(posedge clk);
               #1;
            end
            run_fetch(12'h240, 12'd7, 5'd12, 1'b0, 0);

            // Back-pressure in HOLD with a stray start that must be ignored.
            issue_fetch(12'h555, 12'd2, 5'd8, 1'b0);
            wait_valid(ok);
            if (ok) begin
               for (int t = 0; t < 10; t++) begin
                  start     = (t == 3);
                  base_addr = 12'h0AA;
                  @(posedge clk);
                  #1;
               end
               start = 1'b0;
               ready = 1'b1;
               @(posedge clk);
               #1;
               ready = 1'b0;
               @(posedge clk);
               #1;
               check("hold_drained", exp_q0.size() + exp_q1.size() + addr_q0.size()
                     + addr_q1.size(), 0);
            end else begin
               apply_reset();
            end

            // RESET one cycle after the last issue: no late capture, no valid.
            issue_fetch(12'h300, 12'd1, 5'd2, 1'b0);
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            apply_reset();
            for (int t = 0; t < 6; t++) begin
               check_quiet("mid_reset");
               @(posedge clk);
               #1;
            end
            run_fetch(12'h310, 12'd1, 5'd3, 1'b0, 0);
         end
         begin : monitor
            forever begin
               @(negedge clk);
               for (int k = 0; k < 2; k++) mon_inst(k);
            end
         end
         begin : watchdog
            repeat (60000) @(posedge clk);
            check("global_watchdog", cyc, 0);
         end
      join_any
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
